dest_sink: RTL
==============

# dest_sink

Two-channel destination buffer at the far end of the demux outputs. It accepts words pushed on channel 0 (D0) and channel 1 (D1), stores each channel in its own small FIFO, and returns per-channel back-pressure (`pause_d0`, `pause_d1`) to the demux/VC-arbitration stage. A downstream reader drains each channel with a pop/valid handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 6: word width per channel.
- `DEPTH`, 4: entries per channel FIFO; must be a power of two, ≥2.
- `PAUSE_THRESH`, 3: occupancy at or above which pause asserts; 1 ≤ value ≤ DEPTH.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `push_0` / `push_1`  in  1  write strobe for channel 0 / channel 1.
- `data_in0` / `data_in1`  in  DATA_WIDTH  write data, sampled when the matching push is high.
- `pop_0` / `pop_1`  in  1  read request from the downstream reader.
- `data_out0` / `data_out1`  out  DATA_WIDTH  registered read data.
- `valid_out0` / `valid_out1`  out  1  data_out is valid this cycle.
- `pause_d0` / `pause_d1`  out  1  back-pressure to the demux; registered.
- `empty_0` / `empty_1`  out  1  occupancy == 0.
- `full_0` / `full_1`  out  1  occupancy == DEPTH.
- `overflow_0` / `overflow_1`  out  1  sticky; a push was dropped.

## Operation
- The two channels are identical and fully independent. There is no shared state and no arbitration.
- Each channel has write pointer `wr_ptr` and read pointer `rd_ptr` (log2(DEPTH) bits, natural wrap), plus occupancy `count` (log2(DEPTH)+1 bits).
- Push is accepted when `!full` or when a pop is accepted in the same cycle. An accepted push writes `mem[wr_ptr]` and increments `wr_ptr`.
- Push while full with no pop: the word is dropped, pointers and count are unchanged, and `overflow` sets. `overflow` stays set until reset.
- Pop is accepted when `!empty`. An accepted pop registers `mem[rd_ptr]` into `data_out`, sets `valid_out`, and increments `rd_ptr`.
- Pop while empty: ignored. `valid_out` is 0 and `data_out` holds its last value.
- Count: +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Simultaneous push and pop on an empty channel: the pop is ignored, the push is accepted, and count becomes 1. There is no fall-through.
- `pause_dX` is registered from next-state occupancy: `count_next >= PAUSE_THRESH`.
- `empty` and `full` decode combinationally from the current `count`.

## Timing
- Reset values: pointers = 0, count = 0, `data_out` = 0, `valid_out` = 0, `pause_d*` = 0, `overflow_*` = 0. Consequently `empty_*` = 1 and `full_*` = 0.
- Reset asserted mid-operation clears everything on that edge. Stored words are discarded, and pushes or pops in that cycle are ignored.
- Write latency: a word pushed at edge N is poppable with a pop asserted in cycle N+1.
- Read latency: pop at edge N produces `data_out`/`valid_out` during cycle N+1. `valid_out` is a single-cycle pulse per accepted pop.
- Pause latency: the push that brings count to PAUSE_THRESH raises `pause_dX` in the very next cycle. The pop that brings count below PAUSE_THRESH drops it in the next cycle.
- Upstream may keep pushing for one cycle after pause rises. PAUSE_THRESH < DEPTH guarantees that word is absorbed.
- Full/overflow: the drop decision uses current-cycle `full` and the current-cycle pop. `overflow` is visible the cycle after the dropped push.

## Configuration
- `DEST_SINK_STATS_EN`
  - Defined: adds outputs `rx_cnt0` and `rx_cnt1` (8 bits each). Each counts accepted pushes on its channel, saturates at 255, and resets to 0.
  - Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then push_0 with 0x2A, 0x2C, 0x2E on three consecutive edges → `pause_d0` = 1 from the cycle after the third push, `empty_0` = 0. Channel 1 is unaffected: `empty_1` = 1, `pause_d1` = 0.
- Fill channel 1 with 0x15, 0x17, 0x19, 0x1B, then push 0x1D → `full_1` = 1, `overflow_1` = 1 next cycle. Four pops return 0x15, 0x17, 0x19, 0x1B, 0x1D never appears, and `empty_1` = 1 afterward.
- Channel 0 full with 0x2A..0x30 (step 2); push 0x32 and pop in the same cycle → `data_out0` = 0x2A next cycle, count stays 4, `overflow_0` = 0. Subsequent pops return 0x2C, 0x2E, 0x30, 0x32.
- Pop_0 on empty after reset → `valid_out0` = 0, `data_out0` = 0. Push 0x2A with a simultaneous pop → count 1, and the next pop returns 0x2A.
- Push 3 words on both channels, assert reset for one edge together with push_0 = 1 → all counts 0, `pause_d*` = 0, `overflow_*` = 0. A following pop yields `valid_out` = 0.
- With `DEST_SINK_STATS_EN` defined: 300 accepted pushes on channel 0 (with interleaved pops) → `rx_cnt0` = 255 and `rx_cnt1` = 0.

Source files
------------

// File: rtl/dest_sink.sv
// Two-channel destination FIFO with registered per-channel pause back-pressure.
// Optional feature: define DEST_SINK_STATS_EN to add saturating accepted-push counters rx_cnt0/rx_cnt1.
module dest_sink #(
    parameter int DATA_WIDTH   = 6,
    parameter int DEPTH        = 4,
    parameter int PAUSE_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_0,
    input  logic                  push_1,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic                  pop_0,
    input  logic                  pop_1,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic                  valid_out0,
    output logic                  valid_out1,
    output logic                  pause_d0,
    output logic                  pause_d1,
    output logic                  empty_0,
    output logic                  empty_1,
    output logic                  full_0,
    output logic                  full_1,
    output logic                  overflow_0,
`ifdef DEST_SINK_STATS_EN
    output logic                  overflow_1,
    output logic [7:0]            rx_cnt0,
    output logic [7:0]            rx_cnt1
`else
    output logic                  overflow_1
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   THRESH_C = (AW+1)'(PAUSE_THRESH);
    localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    logic [1:0]            push_s;
    logic [1:0]            pop_s;
    logic [1:0]            valid_s;
    logic [1:0]            pause_s;
    logic [1:0]            empty_s;
    logic [1:0]            full_s;
    logic [1:0]            ovf_s;
    logic [DATA_WIDTH-1:0] din_s  [2];
    logic [DATA_WIDTH-1:0] dout_s [2];

    assign push_s   = {push_1, push_0};
    assign pop_s    = {pop_1, pop_0};
    assign din_s[0] = data_in0;
    assign din_s[1] = data_in1;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]         wr_ptr_q;
        logic [AW-1:0]         rd_ptr_q;
        logic [AW:0]           count_q;
        logic [AW:0]           count_d;
        logic                  push_ok_s;
        logic                  pop_ok_s;
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;
        logic                  pause_q;
        logic                  ovf_q;

        assign empty_s[ch] = (count_q == '0);
        assign full_s[ch]  = (count_q == DEPTH_C);

        // Accept decisions and next occupancy; a pop frees the slot for a push while full.
        always_comb begin
            pop_ok_s  = pop_s[ch] && !empty_s[ch];
            push_ok_s = push_s[ch] && (!full_s[ch] || pop_ok_s);
            count_d   = count_q;
            if (push_ok_s && !pop_ok_s) begin
                count_d = count_q + ONE_C;
            end else if (!push_ok_s && pop_ok_s) begin
                count_d = count_q - ONE_C;
            end else begin
                count_d = count_q;
            end
        end

        // Channel storage, pointers, read register and sticky overflow.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                dout_q   <= '0;
                valid_q  <= 1'b0;
                pause_q  <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                if (push_ok_s) begin
                    mem_q[wr_ptr_q] <= din_s[ch];
                    wr_ptr_q        <= wr_ptr_q + PTR_ONE_C;
                end
                if (pop_ok_s) begin
                    dout_q   <= mem_q[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + PTR_ONE_C;
                end
                valid_q <= pop_ok_s;
                count_q <= count_d;
                pause_q <= (count_d >= THRESH_C);
                if (push_s[ch] && !push_ok_s) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign dout_s[ch]  = dout_q;
        assign valid_s[ch] = valid_q;
        assign pause_s[ch] = pause_q;
        assign ovf_s[ch]   = ovf_q;

`ifdef DEST_SINK_STATS_EN
        logic [7:0] rx_q;

        // Saturating count of accepted pushes.
        always_ff @(posedge clk) begin
            if (reset) begin
                rx_q <= 8'd0;
            end else if (push_ok_s && (rx_q != 8'hFF)) begin
                rx_q <= rx_q + 8'd1;
            end
        end

        if (ch == 0) begin : g_rx0
            assign rx_cnt0 = rx_q;
        end else begin : g_rx1
            assign rx_cnt1 = rx_q;
        end
`endif
    end

    assign data_out0  = dout_s[0];
    assign data_out1  = dout_s[1];
    assign valid_out0 = valid_s[0];
    assign valid_out1 = valid_s[1];
    assign pause_d0   = pause_s[0];
    assign pause_d1   = pause_s[1];
    assign empty_0    = empty_s[0];
    assign empty_1    = empty_s[1];
    assign full_0     = full_s[0];
    assign full_1     = full_s[1];
    assign overflow_0 = ovf_s[0];
    assign overflow_1 = ovf_s[1];

endmodule
